// File: rtl/stream_pattern_checker.sv
// rtl/stream_pattern_checker.sv - byte stream checker against an arithmetic SEED + k*STEP sequence
module stream_pattern_checker #(
    parameter logic [7:0] SEED  = 8'h11,
    parameter logic [7:0] STEP  = 8'h11,
    parameter int         LEN   = 10,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_flag,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_err,
    output logic [15:0]      first_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [15:0]      LAST_IDX = 16'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       expected_q, expected_d;
    logic [15:0]      idx_q, idx_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             err_flag_q, err_flag_d;
    logic [7:0]       first_err_q, first_err_d;
    logic [15:0]      first_idx_q, first_idx_d;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        idx_d       = idx_q;
        match_d     = match_q;
        err_d       = err_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;
        first_idx_d = first_idx_q;

        // start wins over any same-cycle sample, which is dropped uncompared
        if (start) begin
            state_d     = S_CHECK;
            expected_d  = SEED;
            idx_d       = 16'd0;
            match_d     = '0;
            err_d       = '0;
            err_flag_d  = 1'b0;
            first_err_d = 8'd0;
            first_idx_d = 16'd0;
        end else if (state_q == S_CHECK && data_valid) begin
            if (data_in == expected_q) begin
                if (match_q != CNT_MAX) match_d = match_q + CNT_ONE;
            end else begin
                if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_err_d = data_in;
                    first_idx_d = idx_q;
                end
            end
            expected_d = expected_q + STEP;
            idx_d      = idx_q + 16'd1;
            if (idx_q == LAST_IDX) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            expected_q  <= 8'd0;
            idx_q       <= 16'd0;
            match_q     <= '0;
            err_q       <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= 8'd0;
            first_idx_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            idx_q       <= idx_d;
            match_q     <= match_d;
            err_q       <= err_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign busy        = (state_q == S_CHECK);
    assign done        = (state_q == S_DONE);
    assign pass        = done && (err_q == '0);
    assign err_flag    = err_flag_q;
    assign match_count = match_q;
    assign err_count   = err_q;
    assign first_err   = first_err_q;
    assign first_idx   = first_idx_q;

endmodule
